// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory stage of the pipelined core. Sits directly after the EX/MEM register,
// runs loads and stores over a req/ack data-memory handshake, holds the EX/MEM
// register (stallM) while an access is outstanding, and registers the W-stage
// bundle for writeback.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   validM .. WriteDataM  M-stage bundle from the EX/MEM register
//   stallM                combinational hold request to the EX/MEM register
//   mem_req/we/addr/wdata registered request to data memory (word address)
//   mem_ack, mem_rdata    completion strobe and load data from data memory
//   validW .. ReadDataW   registered W-stage bundle
//   timeout_err           sticky access-timeout flag
//
// Build option
//   MEM_TIMEOUT_EN  when defined, an access that waits TIMEOUT_CYCLES BUSY
//                   cycles without mem_ack is aborted and timeout_err is set.
//                   When undefined, BUSY waits for mem_ack indefinitely and
//                   timeout_err is tied low.
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             reset,
   // M-stage bundle
   input  logic             validM,
   input  logic             PCSrcM,
   input  logic             RegWriteM,
   input  logic             MemWriteM,
   input  logic             MemtoRegM,
   input  logic [3:0]       WA3M,
   input  logic [WIDTH-1:0] ALUResultM,
   input  logic [WIDTH-1:0] WriteDataM,
   output logic             stallM,
   // data-memory handshake
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata,
   // W-stage bundle
   output logic             validW,
   output logic             PCSrcW,
   output logic             RegWriteW,
   output logic             MemtoRegW,
   output logic [3:0]       WA3W,
   output logic [WIDTH-1:0] ALUOutW,
   output logic [WIDTH-1:0] ReadDataW,
   output logic             timeout_err
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state_reg,     state_next;
   logic             mem_req_reg,   mem_req_next;
   logic             mem_we_reg,    mem_we_next;
   logic [WIDTH-1:0] mem_addr_reg,  mem_addr_next;
   logic [WIDTH-1:0] mem_wdata_reg, mem_wdata_next;

   logic             validW_reg,    validW_next;
   logic             PCSrcW_reg,    PCSrcW_next;
   logic             RegWriteW_reg, RegWriteW_next;
   logic             MemtoRegW_reg, MemtoRegW_next;
   logic [3:0]       WA3W_reg,      WA3W_next;
   logic [WIDTH-1:0] ALUOutW_reg,   ALUOutW_next;
   logic [WIDTH-1:0] ReadDataW_reg, ReadDataW_next;

   logic             memop;
   logic             abort;
   logic [WIDTH-1:0] aligned_addr;

   assign memop = validM & (MemWriteM | MemtoRegM);

   // Word-align the address: the two byte-offset bits are dropped, no
   // misalignment check is made.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_align
         if (gi < 2) begin : g_low
            assign aligned_addr[gi] = 1'b0;
         end else begin : g_high
            assign aligned_addr[gi] = ALUResultM[gi];
         end
      end
   endgenerate

`ifdef MEM_TIMEOUT_EN
   // Counter is at least 8 bits wide, wider if TIMEOUT_CYCLES needs it.
   localparam int CNT_BITS = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                             $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_BITS-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic                timeout_err_reg, timeout_err_next;

   // The counter holds the number of ack-less BUSY cycles already completed,
   // so the BUSY cycle in which it equals TIMEOUT_CYCLES-1 is the last one
   // allowed; that cycle becomes the abort cycle.
   assign abort = (state_reg == BUSY) && !mem_ack &&
                  (tmo_cnt_reg == CNT_BITS'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_cnt_next     = tmo_cnt_reg;
      timeout_err_next = timeout_err_reg | abort;
      if (state_reg == IDLE) begin
         // Held at zero in IDLE, so every BUSY entry starts from a clear count.
         tmo_cnt_next = '0;
      end else if (!mem_ack) begin
         tmo_cnt_next = tmo_cnt_reg + CNT_BITS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt_reg     <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         tmo_cnt_reg     <= tmo_cnt_next;
         timeout_err_reg <= timeout_err_next;
      end
   end

   assign timeout_err = timeout_err_reg;
`else
   // No watchdog: BUSY waits for mem_ack for as long as it takes.
   // TIMEOUT_CYCLES is still referenced so both builds share one interface.
   assign abort       = 1'b0 && (TIMEOUT_CYCLES != 0);
   assign timeout_err = 1'b0;
`endif

   // Next-state, request and W-stage logic.
   always_comb begin
      state_next     = state_reg;
      mem_req_next   = mem_req_reg;
      mem_we_next    = mem_we_reg;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      stallM         = 1'b0;

      // Default W content is a bubble: slot invalid, no side effects.
      validW_next    = 1'b0;
      PCSrcW_next    = 1'b0;
      RegWriteW_next = 1'b0;
      MemtoRegW_next = MemtoRegM;
      WA3W_next      = WA3M;
      ALUOutW_next   = ALUResultM;
      ReadDataW_next = '0;

      unique case (state_reg)
         IDLE: begin
            if (memop) begin
               // Request cycle: latch the access and hold upstream.
               mem_req_next   = 1'b1;
               mem_we_next    = MemWriteM;
               mem_addr_next  = aligned_addr;
               mem_wdata_next = WriteDataM;
               state_next     = BUSY;
               stallM         = 1'b1;
            end else begin
               validW_next    = validM;
               PCSrcW_next    = PCSrcM;
               RegWriteW_next = RegWriteM;
            end
         end

         BUSY: begin
            if (mem_ack) begin
               // Completion: retire the instruction; only loads carry data,
               // decided from the latched direction.
               validW_next    = 1'b1;
               PCSrcW_next    = PCSrcM;
               RegWriteW_next = RegWriteM;
               ReadDataW_next = mem_we_reg ? '0 : mem_rdata;
               mem_req_next   = 1'b0;
               state_next     = IDLE;
            end else if (abort) begin
               // Timed out: retire without writeback so the pipeline moves on.
               validW_next    = 1'b1;
               PCSrcW_next    = PCSrcM;
               RegWriteW_next = 1'b0;
               mem_req_next   = 1'b0;
               state_next     = IDLE;
            end else begin
               stallM = memop;
            end
         end

         default: begin
            state_next   = IDLE;
            mem_req_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         validW_reg    <= 1'b0;
         PCSrcW_reg    <= 1'b0;
         RegWriteW_reg <= 1'b0;
         MemtoRegW_reg <= 1'b0;
         WA3W_reg      <= '0;
         ALUOutW_reg   <= '0;
         ReadDataW_reg <= '0;
      end else begin
         state_reg     <= state_next;
         mem_req_reg   <= mem_req_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
         validW_reg    <= validW_next;
         PCSrcW_reg    <= PCSrcW_next;
         RegWriteW_reg <= RegWriteW_next;
         MemtoRegW_reg <= MemtoRegW_next;
         WA3W_reg      <= WA3W_next;
         ALUOutW_reg   <= ALUOutW_next;
         ReadDataW_reg <= ReadDataW_next;
      end
   end

   assign mem_req   = mem_req_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign validW    = validW_reg;
   assign PCSrcW    = PCSrcW_reg;
   assign RegWriteW = RegWriteW_reg;
   assign MemtoRegW = MemtoRegW_reg;
   assign WA3W      = WA3W_reg;
   assign ALUOutW   = ALUOutW_reg;
   assign ReadDataW = ReadDataW_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed self-checking bench for mem_access_unit. Inputs change 2 time units
// after the rising edge; outputs are sampled 1 time unit later, well clear of
// the next edge. Build with MEM_TIMEOUT_EN defined to exercise the abort path
// (TIMEOUT_CYCLES = 4 here).
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int WIDTH = 32;
   localparam int TMO   = 4;

   logic             clk;
   logic             reset;
   logic             validM, PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
   logic [3:0]       WA3M;
   logic [WIDTH-1:0] ALUResultM, WriteDataM;
   logic             stallM;
   logic             mem_req, mem_we;
   logic [WIDTH-1:0] mem_addr, mem_wdata;
   logic             mem_ack;
   logic [WIDTH-1:0] mem_rdata;
   logic             validW, PCSrcW, RegWriteW, MemtoRegW;
   logic [3:0]       WA3W;
   logic [WIDTH-1:0] ALUOutW, ReadDataW;
   logic             timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Values captured in the first BUSY cycle of an access.
   logic             req_seen, we_seen, bubble_seen;
   logic [WIDTH-1:0] addr_seen, wdata_seen;
   int               stall_cnt;

   mem_access_unit #(
      .WIDTH          (WIDTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .validM      (validM),
      .PCSrcM      (PCSrcM),
      .RegWriteM   (RegWriteM),
      .MemWriteM   (MemWriteM),
      .MemtoRegM   (MemtoRegM),
      .WA3M        (WA3M),
      .ALUResultM  (ALUResultM),
      .WriteDataM  (WriteDataM),
      .stallM      (stallM),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .validW      (validW),
      .PCSrcW      (PCSrcW),
      .RegWriteW   (RegWriteW),
      .MemtoRegW   (MemtoRegW),
      .WA3W        (WA3W),
      .ALUOutW     (ALUOutW),
      .ReadDataW   (ReadDataW),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to 2 time units after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic set_m(input logic v, input logic pcs, input logic rw, input logic mw,
                        input logic m2r, input logic [3:0] wa, input logic [31:0] alu,
                        input logic [31:0] wd);
      validM     = v;
      PCSrcM     = pcs;
      RegWriteM  = rw;
      MemWriteM  = mw;
      MemtoRegM  = m2r;
      WA3M       = wa;
      ALUResultM = alu;
      WriteDataM = wd;
   endtask

   // Run one memop already presented on the M inputs: request cycle, then
   // ack_wait BUSY cycles without ack, then one BUSY cycle with ack.
   // Returns 2 time units after the ack edge.
   task automatic run_memop(input int ack_wait, input logic [31:0] rdata);
      stall_cnt = 0;
      for (int c = 0; c <= ack_wait + 1; c++) begin
         if (c == ack_wait + 1) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
         end
         #1;
         if (stallM) stall_cnt++;
         if (c == 1) begin
            req_seen    = mem_req;
            we_seen     = mem_we;
            addr_seen   = mem_addr;
            wdata_seen  = mem_wdata;
            bubble_seen = validW;
         end
         @(posedge clk);
         #2;
         mem_ack   = 1'b0;
         mem_rdata = 32'h0;
      end
   endtask

   initial begin
      reset     = 1'b1;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      set_m(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

      // ---- reset held two cycles ----
      cyc();
      cyc();
      #1;
      check_eq("rst_stallM",    stallM,      1'b0);
      check_eq("rst_mem_req",   mem_req,     1'b0);
      check_eq("rst_mem_we",    mem_we,      1'b0);
      check_eq("rst_mem_addr",  mem_addr,    32'h0);
      check_eq("rst_mem_wdata", mem_wdata,   32'h0);
      check_eq("rst_validW",    validW,      1'b0);
      check_eq("rst_PCSrcW",    PCSrcW,      1'b0);
      check_eq("rst_RegWriteW", RegWriteW,   1'b0);
      check_eq("rst_MemtoRegW", MemtoRegW,   1'b0);
      check_eq("rst_WA3W",      WA3W,        4'h0);
      check_eq("rst_ALUOutW",   ALUOutW,     32'h0);
      check_eq("rst_ReadDataW", ReadDataW,   32'h0);
      check_eq("rst_timeout",   timeout_err, 1'b0);
      $display("txn reset: outputs after 2 reset cycles checked");
      cyc();
      reset = 1'b0;

      // ---- ALU op, one-cycle pass-through ----
      set_m(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 32'h12, 32'h0);
      #1;
      check_eq("alu_stallM", stallM, 1'b0);
      cyc();
      #1;
      check_eq("alu_validW",    validW,    1'b1);
      check_eq("alu_PCSrcW",    PCSrcW,    1'b1);
      check_eq("alu_RegWriteW", RegWriteW, 1'b1);
      check_eq("alu_WA3W",      WA3W,      4'h3);
      check_eq("alu_ALUOutW",   ALUOutW,   32'h12);
      check_eq("alu_ReadDataW", ReadDataW, 32'h0);
      check_eq("alu_mem_req",   mem_req,   1'b0);
      $display("txn alu: WA3W=%0h ALUOutW=%h", WA3W, ALUOutW);

      // ---- load at 0x103, ack in the 4th BUSY cycle ----
      set_m(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 32'h103, 32'h0);
      run_memop(3, 32'hDEADBEEF);
      #1;
      check_eq("ld_stall_cycles", stall_cnt,   32'd4);
      check_eq("ld_req",          req_seen,    1'b1);
      check_eq("ld_we",           we_seen,     1'b0);
      check_eq("ld_addr",         addr_seen,   32'h100);
      check_eq("ld_bubble",       bubble_seen, 1'b0);
      check_eq("ld_ReadDataW",    ReadDataW,   32'hDEADBEEF);
      check_eq("ld_MemtoRegW",    MemtoRegW,   1'b1);
      check_eq("ld_validW",       validW,      1'b1);
      check_eq("ld_RegWriteW",    RegWriteW,   1'b1);
      check_eq("ld_WA3W",         WA3W,        4'h5);
      check_eq("ld_req_drop",     mem_req,     1'b0);
      $display("txn load: addr=%h rdata=%h stall=%0d", addr_seen, ReadDataW, stall_cnt);

      // ---- store, immediate ack; rdata driven nonzero to be ignored ----
      set_m(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h202, 32'hA5A5A5A5);
      run_memop(0, 32'h11111111);
      #1;
      check_eq("st_stall_cycles", stall_cnt,  32'd1);
      check_eq("st_we",           we_seen,    1'b1);
      check_eq("st_wdata",        wdata_seen, 32'hA5A5A5A5);
      check_eq("st_addr",         addr_seen,  32'h200);
      check_eq("st_ReadDataW",    ReadDataW,  32'h0);
      check_eq("st_validW",       validW,     1'b1);
      check_eq("st_req_gap",      mem_req,    1'b0);
      $display("txn store: addr=%h wdata=%h stall=%0d", addr_seen, wdata_seen, stall_cnt);

      // ---- back-to-back load, ack in the 2nd BUSY cycle ----
      set_m(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 32'h44, 32'h0);
      run_memop(1, 32'hCAFEF00D);
      #1;
      check_eq("b2b_stall_cycles", stall_cnt, 32'd2);
      check_eq("b2b_addr",         addr_seen, 32'h44);
      check_eq("b2b_ReadDataW",    ReadDataW, 32'hCAFEF00D);
      check_eq("b2b_WA3W",         WA3W,      4'h9);
      $display("txn load b2b: addr=%h rdata=%h stall=%0d", addr_seen, ReadDataW, stall_cnt);

      // ---- mem_ack while IDLE is ignored ----
      set_m(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      mem_ack   = 1'b1;
      mem_rdata = 32'h55AA55AA;
      cyc();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      #1;
      check_eq("idle_ack_req",      mem_req,   1'b0);
      check_eq("idle_ack_validW",   validW,    1'b0);
      check_eq("idle_ack_ReadData", ReadDataW, 32'h0);
      $display("txn idle ack: ignored");

`ifdef MEM_TIMEOUT_EN
      // ---- timeout abort after TMO BUSY cycles with no ack ----
      set_m(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 32'h80, 32'h0);
      stall_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         logic s;
         #1;
         s = stallM;
         if (s) stall_cnt++;
         cyc();
         if (!s) break;
      end
      #1;
      check_eq("tmo_stall_cycles", stall_cnt,   32'd4);
      check_eq("tmo_err",          timeout_err, 1'b1);
      check_eq("tmo_validW",       validW,      1'b1);
      check_eq("tmo_RegWriteW",    RegWriteW,   1'b0);
      check_eq("tmo_ReadDataW",    ReadDataW,   32'h0);
      check_eq("tmo_req_drop",     mem_req,     1'b0);
      set_m(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 32'h7, 32'h0);
      cyc();
      #1;
      check_eq("tmo_err_sticky",   timeout_err, 1'b1);
      check_eq("tmo_after_validW", validW,      1'b1);
      $display("txn timeout: stall=%0d timeout_err=%0b", stall_cnt, timeout_err);
`endif

      // ---- load at 0x3F left waiting, then reset mid-access ----
      set_m(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h7, 32'h3F, 32'h0);
      cyc();
      #1;
      check_eq("wait_req",  mem_req,  1'b1);
      check_eq("wait_addr", mem_addr, 32'h3C);
`ifndef MEM_TIMEOUT_EN
      // Without the watchdog the access must wait as long as it takes.
      for (int c = 0; c < 10; c++) cyc();
      #1;
      check_eq("wait_long_req",   mem_req,     1'b1);
      check_eq("wait_long_stall", stallM,      1'b1);
      check_eq("wait_long_tmo",   timeout_err, 1'b0);
`endif
      reset = 1'b1;
      set_m(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      cyc();
      #1;
      check_eq("rstb_mem_req",  mem_req,     1'b0);
      check_eq("rstb_mem_addr", mem_addr,    32'h0);
      check_eq("rstb_validW",   validW,      1'b0);
      check_eq("rstb_WA3W",     WA3W,        4'h0);
      check_eq("rstb_ALUOutW",  ALUOutW,     32'h0);
      check_eq("rstb_tmo",      timeout_err, 1'b0);
      reset     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'h12345678;
      cyc();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      #1;
      check_eq("late_ack_req",      mem_req,   1'b0);
      check_eq("late_ack_validW",   validW,    1'b0);
      check_eq("late_ack_ReadData", ReadDataW, 32'h0);
      check_eq("late_ack_stallM",   stallM,    1'b0);
      $display("txn reset mid-access: late ack ignored");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
